// File: rtl/call_stack.sv
// Return-address LIFO for the CPU pipeline: push on call, pop on return, sticky overflow/underflow flags.
// Build option CALL_STACK_WRAP_EN: a push while full overwrites the oldest entry instead of being dropped.
module call_stack #(
    parameter int AW    = 12,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [AW-1:0] retAddr,
    output logic [AW-1:0] top,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    localparam int SPW = $clog2(DEPTH);

    logic [AW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  mem_d [DEPTH];
    logic [SPW-1:0] sp_q, sp_d, sp_m1;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic           is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign sp_m1    = sp_q - SPW'(1);

    always_comb begin
        mem_d   = mem_q;
        sp_d    = sp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (flush) begin
            sp_d    = '0;
            count_d = '0;
        end else if (push && pop && !is_empty) begin
            mem_d[sp_m1] = retAddr;
        end else if (push) begin
            // reaching here with pop set means the stack was empty
            if (pop) begin
                unf_d = 1'b1;
            end
            if (!is_full) begin
                mem_d[sp_q] = retAddr;
                sp_d        = sp_q + SPW'(1);
                count_d     = count_q + CW'(1);
            end else begin
                ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                mem_d[sp_q] = retAddr;
                sp_d        = sp_q + SPW'(1);
`endif
            end
        end else if (pop) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d    = sp_m1;
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign top       = is_empty ? '0 : mem_q[sp_m1];
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed vector bench for call_stack; expectations follow CALL_STACK_WRAP_EN when it is defined.
module tb_call_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic        push, pop, flush;
    logic [11:0] retAddr;
    logic [11:0] top;
    logic [3:0]  count;
    logic        empty, full, overflow, underflow;

    int errors = 0;
    int checks = 0;

    call_stack #(.AW(12), .DEPTH(8), .CW(4)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
        .retAddr(retAddr), .top(top), .count(count), .empty(empty),
        .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic        flush;
        logic [11:0] addr;
        logic [11:0] etop;
        logic [3:0]  ecnt;
        logic        eovf;
        logic        eunf;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic pu, input logic po, input logic fl,
                                input logic [11:0] a, input logic [11:0] et,
                                input logic [3:0] ec, input logic eo, input logic eu);
        vec_t v;
        v.push = pu; v.pop = po; v.flush = fl; v.addr = a;
        v.etop = et; v.ecnt = ec; v.eovf = eo; v.eunf = eu;
        return v;
    endfunction

    task automatic check(input string name, input logic [11:0] etop, input logic [3:0] ecnt,
                         input logic eovf, input logic eunf);
        logic [19:0] act, exp;
        act = {top, count, empty, full, overflow, underflow};
        exp = {etop, ecnt, (ecnt == 4'd0), (ecnt == 4'd8), eovf, eunf};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got top=%h count=%0d empty=%b full=%b ovf=%b unf=%b, expected top=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                     name, top, count, empty, full, overflow, underflow,
                     etop, ecnt, exp[5], exp[4], eovf, eunf);
        end
    endtask

    // drive for one clock edge, then return with inputs idle and outputs settled
    task automatic step(input logic pu, input logic po, input logic fl, input logic [11:0] a);
        push = pu; pop = po; flush = fl; retAddr = a;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; retAddr = '0;
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 12'h010, 12'h010, 4'd1, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 12'h020, 12'h020, 4'd2, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 12'h030, 12'h030, 4'd3, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h020, 4'd2, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h010, 4'd1, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 4'd0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 4'd0, 1'b0, 1'b1);
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, 12'h0AB, 12'h0AB, 4'd1, 1'b0, 1'b1);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 12'h055, 12'h055, 4'd2, 1'b0, 1'b1);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 12'h077, 12'h077, 4'd2, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h0AB, 4'd1, 1'b0, 1'b1);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 4'd0, 1'b0, 1'b1);
        vecs[12] = mk(1'b1, 1'b1, 1'b0, 12'h0CC, 12'h0CC, 4'd1, 1'b0, 1'b1);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 4'd0, 1'b0, 1'b1);

        rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; retAddr = '0;
        #12;
        check("reset", 12'h000, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].addr);
            check($sformatf("vec%0d", i), vecs[i].etop, vecs[i].ecnt, vecs[i].eovf, vecs[i].eunf);
        end

        // clear sticky underflow before the full/overflow sequence
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset2", 12'h000, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 12'(i));
            check($sformatf("fill%0d", i), 12'(i), 4'(i), 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 12'h009);
`ifdef CALL_STACK_WRAP_EN
        check("push_full", 12'h009, 4'd8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wrap_top%0d", i), 12'(9 - i), 4'(8 - i), 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0, 12'h000);
        end
`else
        check("push_full", 12'h008, 4'd8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drop_top%0d", i), 12'(8 - i), 4'(8 - i), 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0, 12'h000);
        end
`endif
        check("drained", 12'h000, 4'd0, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 12'h100 + 12'(i));
        end
        check("five", 12'h104, 4'd5, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 12'h3FF);
        check("flush_push", 12'h000, 4'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 12'h222);
        check("after_flush", 12'h222, 4'd1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'h000);
        step(1'b0, 1'b1, 1'b0, 12'h000);
        check("pop_empty", 12'h000, 4'd0, 1'b1, 1'b1);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 12'h200 + 12'(i));
        end
        check("four", 12'h203, 4'd4, 1'b1, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", 12'h000, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 12'h0EE);
        check("post_rst", 12'h0EE, 4'd1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware return-address stack for the pipelined CPU; sits directly downstream of the instruction controller and consumes its push/pop strobes.
- On a call (jump-and-link), the datapath presents the return address and the controller asserts push. On a return, the controller asserts pop and the fetch stage loads the PC from top.
- Storage is a register-file LIFO with sticky error flags for overflow and underflow.

Parameters:
- AW, 12, address width; matches the 12-bit PC.
- DEPTH, 8, number of entries; power of two, ≥2.
- CW, 4, count width; must satisfy 2^CW > DEPTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  write retAddr onto the stack this cycle.
- pop  input  1  remove the top entry this cycle.
- flush  input  1  synchronous clear of stack contents (pipeline restart).
- retAddr  input  AW  return address to push.
- top  output  AW  current top entry; 0 when empty.
- count  output  CW  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; a push was attempted while full.
- underflow  output  1  sticky; a pop was attempted while empty.

Behaviour:
- Reset (async, rst=1): count=0, write pointer=0, overflow=0, underflow=0, storage cleared to 0. Resulting outputs: top=0, empty=1, full=0.
- State: storage array mem[0..DEPTH-1], stack pointer sp (next free slot, log2(DEPTH) bits), count.
- top is combinational: mem[sp-1] (modulo DEPTH) when count>0, else 0.
- Read latency: zero. Write latency: one cycle; a value pushed at edge N appears on top after edge N.
- Priority per cycle: flush > push/pop. flush=1 sets count=0 and sp=0; storage is untouched; sticky flags are kept.
- push only, not full: mem[sp]<=retAddr, sp<=sp+1, count<=count+1.
- pop only, not empty: sp<=sp-1, count<=count-1. The popped entry is not cleared.
- push and pop together, count>0: top is replaced in place (mem[sp-1]<=retAddr); sp and count are unchanged.
- push and pop together, count==0: treated as a push; underflow is set.
- pop when empty: no state change; underflow<=1.
- push when full: see Optional Feature. overflow<=1 in both builds.
- Sticky flags clear only on rst.
- Wrap-around: sp arithmetic is modulo DEPTH. count never exceeds DEPTH and never goes below 0.
- Reset mid-operation overrides everything immediately, with no clock required.
- No handshake back-pressure: the controller never stalls on this block. Errors are reported only through the flags.

Optional Feature:
- Macro: CALL_STACK_WRAP_EN.
- Defined: push when full overwrites the oldest entry circularly. Effects: mem[sp]<=retAddr, sp<=sp+1, count stays DEPTH, overflow<=1. The newest DEPTH return addresses are always preserved.
- Undefined: push when full is dropped. mem, sp and count are unchanged, overflow<=1, and top keeps its prior value.

Test Plan:
1. Reset, then push 0x010, 0x020, 0x030 on consecutive cycles -> top=0x030, count=3. Pop three times -> top 0x020, 0x010, then 0 with empty=1, underflow=0.
2. Pop while empty -> count=0, top=0, underflow=1. Then push 0x0AB -> top=0x0AB, underflow still 1.
3. With count=2 and top=0x055, assert push and pop together with retAddr=0x077 -> top=0x077, count=2. A following pop -> top shows the original entry beneath.
4. Push 0x001..0x008 (full=1), then push 0x009. Without the macro: top=0x008, count=8, overflow=1. With CALL_STACK_WRAP_EN: top=0x009, count=8, overflow=1, and eight pops return 0x009 down to 0x002.
5. With count=5, assert flush and push together -> count=0, empty=1, top=0, overflow/underflow unchanged.
6. Assert rst asynchronously between clock edges with count=4 -> count=0, empty=1, top=0 and both flags 0 before the next edge.
